// File: rtl/div_stream_master.sv
// -----------------------------------------------------------------------------
// div_stream_master
//
// Requester side of the AXI-stream divider interface. It takes signed operand
// pairs, sends their magnitudes to the divider's dividend/divisor channels and
// re-applies the sign to each {quotient, fraction} beat that comes back.
// Results are returned in issue order through a small result FIFO.
//
// The divider's dout channel has no tready, so every beat must have a slot
// waiting for it. A credit counter (divides issued, result not yet back) plus
// the result-FIFO occupancy is therefore held at or below DEPTH.
//
// Configuration macro: DIV_ZERO_FLAG_EN
//   defined   : divisor==0 is flagged in the sign tag. Such results are
//               replaced by 0x7FFF_FFFF (dividend >= 0) or 0x8000_0000
//               (dividend < 0), and res_divzero is raised with them.
//   undefined : no zero detection. The divider output passes through and
//               res_divzero is tied to 0.
//
// Ports
//   aclk, areset             clock; synchronous active-high reset
//   op_valid/op_ready        operand pair handshake
//   op_dividend, op_divisor  signed operands (DATA_W)
//   m_axis_dividend_*        dividend magnitude channel to the divider
//   m_axis_divisor_*         divisor magnitude channel to the divider
//   s_axis_dout_*            {quotient, fraction} magnitude, no backpressure
//   res_valid/res_ready      result FIFO head handshake
//   res_data, res_divzero    signed result (2*DATA_W) and divide-by-zero flag
//   busy                     credits outstanding or result FIFO non-empty
// -----------------------------------------------------------------------------
module div_stream_master #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_W-1:0]     op_dividend,
  input  logic [DATA_W-1:0]     op_divisor,
  output logic [DATA_W-1:0]     m_axis_dividend_tdata,
  output logic                  m_axis_dividend_tvalid,
  input  logic                  m_axis_dividend_tready,
  output logic [DATA_W-1:0]     m_axis_divisor_tdata,
  output logic                  m_axis_divisor_tvalid,
  input  logic                  m_axis_divisor_tready,
  input  logic [2*DATA_W-1:0]   s_axis_dout_tdata,
  input  logic                  s_axis_dout_tvalid,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*DATA_W-1:0]   res_data,
  output logic                  res_divzero,
  output logic                  busy
);

  localparam int RES_W = 2 * DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
`ifdef DIV_ZERO_FLAG_EN
  // Tag = {divisor_zero, dividend_negative, result_sign}
  localparam int TAG_W = 3;
  localparam int RF_W  = RES_W + 1;
`else
  // Tag = {result_sign}
  localparam int TAG_W = 1;
  localparam int RF_W  = RES_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    // The most negative value maps onto itself and is read as unsigned.
    return x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    credits_q, credits_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [OCC_W-1:0]    occ, occ_next;
  logic [1:0]          ign_cnt_q;
  logic                dvd_vld_q, dvs_vld_q;
  logic [DATA_W-1:0]   dvd_data_q, dvs_data_q;
  logic                err_unexp_q;

  logic [TAG_W-1:0]    tag_mem [DEPTH];
  logic [PTR_W-1:0]    tag_wr_ptr_q, tag_rd_ptr_q;
  logic [TAG_W-1:0]    tag_in, tag_head;

  logic [RF_W-1:0]     res_mem [DEPTH];
  logic [PTR_W-1:0]    res_wr_ptr_q, res_rd_ptr_q;
  logic [RF_W-1:0]     res_word;
  logic [RES_W-1:0]    res_val;

  logic op_fire, issue_done, dout_live, dout_hit, dout_unexp, res_pop;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign occ       = OCC_W'(credits_q) + OCC_W'(fifo_cnt_q);
  assign occ_next  = OCC_W'(credits_d) + OCC_W'(fifo_cnt_d);

  // ign_cnt_q starts at 3 on reset: op_ready stays low for the first cycle
  // after release and dout beats are dropped while it is non-zero.
  assign op_ready  = (state_q == S_IDLE) && (ign_cnt_q != 2'd3) &&
                     (occ < OCC_W'(DEPTH));
  assign op_fire   = op_valid && op_ready;

  // A channel that already completed its handshake counts as done.
  assign issue_done = (state_q == S_ISSUE) &&
                      (!dvd_vld_q || m_axis_dividend_tready) &&
                      (!dvs_vld_q || m_axis_divisor_tready);

  assign dout_live  = s_axis_dout_tvalid && (ign_cnt_q == 2'd0);
  assign dout_hit   = dout_live && (credits_q != '0);
  assign dout_unexp = dout_live && (credits_q == '0);
  assign res_pop    = res_valid && res_ready;

  always_comb begin
    credits_d = credits_q;
    if (issue_done && !dout_hit)      credits_d = credits_q + CNT_W'(1);
    else if (!issue_done && dout_hit) credits_d = credits_q - CNT_W'(1);
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (dout_hit && !res_pop)      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    else if (!dout_hit && res_pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (op_fire) state_d = S_ISSUE;
      S_ISSUE: if (issue_done)
                 state_d = (occ_next == OCC_W'(DEPTH)) ? S_FULL : S_IDLE;
      S_FULL:  if (dout_hit || res_pop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sign tag and result shaping
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_in = '0;
`ifdef DIV_ZERO_FLAG_EN
    tag_in = {(op_divisor == '0), op_dividend[DATA_W-1],
              op_dividend[DATA_W-1] ^ op_divisor[DATA_W-1]};
`else
    tag_in = op_dividend[DATA_W-1] ^ op_divisor[DATA_W-1];
`endif
  end

  assign tag_head = tag_mem[tag_rd_ptr_q];

  always_comb begin
    // Two's complement negate across the full {quotient, fraction} word.
    res_val = tag_head[0] ? (~s_axis_dout_tdata + RES_W'(1)) : s_axis_dout_tdata;
`ifdef DIV_ZERO_FLAG_EN
    if (tag_head[2])
      res_val = tag_head[1] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
    res_word = {tag_head[2], res_val};
`else
    res_word = res_val;
`endif
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      credits_q    <= '0;
      fifo_cnt_q   <= '0;
      ign_cnt_q    <= 2'd3;
      dvd_vld_q    <= 1'b0;
      dvs_vld_q    <= 1'b0;
      dvd_data_q   <= '0;
      dvs_data_q   <= '0;
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      res_wr_ptr_q <= '0;
      res_rd_ptr_q <= '0;
      err_unexp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (ign_cnt_q != 2'd0) ign_cnt_q <= ign_cnt_q - 2'd1;

      if (op_fire) begin
        dvd_vld_q    <= 1'b1;
        dvs_vld_q    <= 1'b1;
        dvd_data_q   <= magnitude(op_dividend);
        dvs_data_q   <= magnitude(op_divisor);
        tag_wr_ptr_q <= tag_wr_ptr_q + PTR_W'(1);
      end else begin
        if (dvd_vld_q && m_axis_dividend_tready) dvd_vld_q <= 1'b0;
        if (dvs_vld_q && m_axis_divisor_tready)  dvs_vld_q <= 1'b0;
      end

      if (dout_hit) begin
        tag_rd_ptr_q <= tag_rd_ptr_q + PTR_W'(1);
        res_wr_ptr_q <= res_wr_ptr_q + PTR_W'(1);
      end
      if (res_pop) res_rd_ptr_q <= res_rd_ptr_q + PTR_W'(1);

      if (dout_unexp) err_unexp_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage is deliberately left without reset; the pointers and
  // count decide what is valid, and the outputs are gated while empty.
  always_ff @(posedge aclk) begin
    if (op_fire)  tag_mem[tag_wr_ptr_q] <= tag_in;
    if (dout_hit) res_mem[res_wr_ptr_q] <= res_word;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_axis_dividend_tdata  = dvd_data_q;
  assign m_axis_dividend_tvalid = dvd_vld_q;
  assign m_axis_divisor_tdata   = dvs_data_q;
  assign m_axis_divisor_tvalid  = dvs_vld_q;

  assign res_valid = (fifo_cnt_q != '0);
  assign res_data  = res_valid ? res_mem[res_rd_ptr_q][RES_W-1:0] : '0;
`ifdef DIV_ZERO_FLAG_EN
  assign res_divzero = res_valid && res_mem[res_rd_ptr_q][RES_W];
`else
  assign res_divzero = 1'b0;
`endif
  assign busy = (credits_q != '0) || (fifo_cnt_q != '0);

  // A dout beat with nothing outstanding means the divider and this block
  // disagree about what is in flight.
  unexpected_dout_beat: assert property (@(posedge aclk) disable iff (areset)
                                         !err_unexp_q);

endmodule
